btb_update_queue: RTL and testbench

Buffers resolved-branch training updates from the backend and writes them into the BTB, one per granted cycle. It is the write side of the BTB, mirroring the prediction pipeline register that carries BTB read results (NextAble/HitBanN/NextPc/NextType) toward fetch. It absorbs bursts of branch resolutions while the BTB write port is busy or stalled.

---
 rtl/btb_update_queue_pkg.sv | 35 +++
 rtl/btb_upd_fifo.sv | 68 ++++++
 rtl/btb_update_queue.sv | 104 ++++++++++
 tb/tb_btb_update_queue.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/btb_update_queue_pkg.sv
// Shared BTB update definitions: branch-type codes (same as BTB NextType),
// default PC width and the training-update record.
// Latency/backpressure: n/a (types and constants only).
package btb_update_queue_pkg;

  localparam int BTB_ADDR_W = 32;
  localparam int BTB_TYPE_W = 3;
  localparam int BTB_BANK_W = 2;

  // Branch type encodings, identical to the BTB NextType field.
  typedef enum logic [BTB_TYPE_W-1:0] {
    BR_NONE     = 3'd0,
    BR_COND     = 3'd1,
    BR_DIRECT   = 3'd2,
    BR_CALL     = 3'd3,
    BR_RET      = 3'd4,
    BR_INDIRECT = 3'd5
  } btb_type_e;

  // One training update at the default PC width.
  typedef struct packed {
    logic [BTB_ADDR_W-1:0] Pc;
    logic [BTB_ADDR_W-1:0] Target;
    logic [BTB_TYPE_W-1:0] Type;
    logic [BTB_BANK_W-1:0] BanN;
    logic                  Taken;
  } btb_upd_t;

  // Flattened entry width for an arbitrary PC width:
  // {Pc, Target, Type, BanN, Taken}.
  function automatic int upd_ent_w(input int addr_w);
    return 2 * addr_w + BTB_TYPE_W + BTB_BANK_W + 1;
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Circular storage for BTB updates: array + head/tail pointers + occupancy.
// Latency: push visible at head one cycle later; no bypass.
// Backpressure: caller must not push when full or pop when empty.
// Optional BTB_UPD_MERGE_EN adds an in-place overwrite of the tail entry.
// Ports: Clk, Rest (async high), PushEn/PushDat, PopEn, HeadDat, Cnt,
//        [merge build] MrgEn (overwrite tail), TailKey (top KEY_W bits of tail).
module btb_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 70,
  parameter int KEY_W = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             Clk,
  input  logic             Rest,
  input  logic             PushEn,
  input  logic [WIDTH-1:0] PushDat,
  input  logic             PopEn,
`ifdef BTB_UPD_MERGE_EN
  input  logic             MrgEn,
  output logic [KEY_W-1:0] TailKey,
`endif
  output logic [WIDTH-1:0] HeadDat,
  output logic [CNT_W-1:0] Cnt
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      Cnt    <= '0;
    end else begin
      if (PushEn) begin
        mem[wr_ptr] <= PushDat;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
`ifdef BTB_UPD_MERGE_EN
      else if (MrgEn) begin
        mem[wr_ptr - PTR_W'(1)] <= PushDat;
      end
`endif
      if (PopEn) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({PushEn, PopEn})
        2'b10:   Cnt <= Cnt + CNT_W'(1);
        2'b01:   Cnt <= Cnt - CNT_W'(1);
        default: Cnt <= Cnt;
      endcase
    end
  end

  assign HeadDat = mem[rd_ptr];

`ifdef BTB_UPD_MERGE_EN
  // The tail entry is the one most recently written.
  logic [PTR_W-1:0] tail_ptr;
  assign tail_ptr = wr_ptr - PTR_W'(1);
  assign TailKey  = mem[tail_ptr][WIDTH-1 -: KEY_W];
`endif

endmodule

// File: rtl/btb_update_queue.sv
// Buffers resolved-branch training updates and issues them as BTB writes.
// Latency: update accepted in cycle N is requested as a write in N+1 (no bypass).
// Backpressure: OtUpdReady low when full (updates then dropped, sticky
// OtOverflow); BUstop or missing InWrAck hold the head entry.
// Ports: Clk, Rest (async high); InUpd* update from backend / OtUpdReady;
//        OtWr* head entry / InWrAck to BTB; OtQueCnt occupancy; OtOverflow.
// Build option BTB_UPD_MERGE_EN: an update with the same PC as the tail
// entry overwrites it in place instead of taking a new slot.
module btb_update_queue
  import btb_update_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = BTB_ADDR_W,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              Clk,
  input  logic              Rest,
  input  logic              BUstop,
  input  logic              InUpdAble,
  input  logic [ADDR_W-1:0] InUpdPc,
  input  logic [ADDR_W-1:0] InUpdTarget,
  input  logic [2:0]        InUpdType,
  input  logic [1:0]        InUpdBanN,
  input  logic              InUpdTaken,
  output logic              OtUpdReady,
  output logic              OtWrAble,
  output logic [ADDR_W-1:0] OtWrPc,
  output logic [ADDR_W-1:0] OtWrTarget,
  output logic [2:0]        OtWrType,
  output logic [1:0]        OtWrBanN,
  output logic              OtWrTaken,
  input  logic              InWrAck,
  output logic [CNT_W-1:0]  OtQueCnt,
  output logic              OtOverflow
);

  localparam int ENT_W = upd_ent_w(ADDR_W);

  logic [ENT_W-1:0] push_dat;
  logic [ENT_W-1:0] head_dat;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             empty;
  logic             deq;
  logic             enq;
  logic             mrg;

  assign push_dat = {InUpdPc, InUpdTarget, InUpdType, InUpdBanN, InUpdTaken};

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

  assign OtWrAble = !empty && !BUstop;
  assign deq      = OtWrAble && InWrAck;

`ifdef BTB_UPD_MERGE_EN
  logic [ADDR_W-1:0] tail_pc;
  // Never merge into a lone entry that is leaving this cycle; the update
  // would be lost with it, so it takes a fresh slot instead.
  assign mrg = InUpdAble && !empty && (InUpdPc == tail_pc)
               && !((cnt == CNT_W'(1)) && deq);
`else
  assign mrg = 1'b0;
`endif

  // Readiness uses the registered count only: a same-cycle dequeue does
  // not free a slot for the incoming update.
  assign OtUpdReady = !full || mrg;
  assign enq        = InUpdAble && !full && !mrg;

  btb_upd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W),
    .KEY_W (ADDR_W)
  ) u_fifo (
    .Clk     (Clk),
    .Rest    (Rest),
    .PushEn  (enq),
    .PushDat (push_dat),
    .PopEn   (deq),
`ifdef BTB_UPD_MERGE_EN
    .MrgEn   (mrg),
    .TailKey (tail_pc),
`endif
    .HeadDat (head_dat),
    .Cnt     (cnt)
  );

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      OtOverflow <= 1'b0;
    end else if (InUpdAble && !OtUpdReady) begin
      OtOverflow <= 1'b1;
    end
  end

  assign OtWrPc     = head_dat[ENT_W-1 -: ADDR_W];
  assign OtWrTarget = head_dat[ENT_W-ADDR_W-1 -: ADDR_W];
  assign OtWrType   = head_dat[5:3];
  assign OtWrBanN   = head_dat[2:1];
  assign OtWrTaken  = head_dat[0];
  assign OtQueCnt   = cnt;

endmodule

// File: tb/tb_btb_update_queue.sv
// Randomized bench for btb_update_queue against a queue-based model.
// Latency/backpressure: drives one update/ack per cycle, checks every cycle.
// Build with BTB_UPD_MERGE_EN to exercise the merge variant.
module tb_btb_update_queue;
  import btb_update_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic        Clk = 1'b0;
  logic        Rest;
  logic        BUstop;
  logic        InUpdAble;
  logic [AW-1:0] InUpdPc;
  logic [AW-1:0] InUpdTarget;
  logic [2:0]  InUpdType;
  logic [1:0]  InUpdBanN;
  logic        InUpdTaken;
  logic        OtUpdReady;
  logic        OtWrAble;
  logic [AW-1:0] OtWrPc;
  logic [AW-1:0] OtWrTarget;
  logic [2:0]  OtWrType;
  logic [1:0]  OtWrBanN;
  logic        OtWrTaken;
  logic        InWrAck;
  logic [2:0]  OtQueCnt;
  logic        OtOverflow;

  int n_chk = 0;
  int n_err = 0;

  btb_upd_t mq[$];
  bit       ovf_m;

  always #5 Clk = ~Clk;

  btb_update_queue #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .Clk         (Clk),
    .Rest        (Rest),
    .BUstop      (BUstop),
    .InUpdAble   (InUpdAble),
    .InUpdPc     (InUpdPc),
    .InUpdTarget (InUpdTarget),
    .InUpdType   (InUpdType),
    .InUpdBanN   (InUpdBanN),
    .InUpdTaken  (InUpdTaken),
    .OtUpdReady  (OtUpdReady),
    .OtWrAble    (OtWrAble),
    .OtWrPc      (OtWrPc),
    .OtWrTarget  (OtWrTarget),
    .OtWrType    (OtWrType),
    .OtWrBanN    (OtWrBanN),
    .OtWrTaken   (OtWrTaken),
    .InWrAck     (InWrAck),
    .OtQueCnt    (OtQueCnt),
    .OtOverflow  (OtOverflow)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop at once.
  task automatic do_reset();
    InUpdAble = 1'b0;
    InWrAck   = 1'b0;
    BUstop    = 1'b0;
    Rest      = 1'b1;
    #1;
    chk("rst_able", OtWrAble, 0);
    chk("rst_cnt",  OtQueCnt, 0);
    chk("rst_rdy",  OtUpdReady, 1);
    chk("rst_ovf",  OtOverflow, 0);
    chk("rst_pc",   OtWrPc, 0);
    chk("rst_tgt",  OtWrTarget, 0);
    chk("rst_misc", {OtWrType, OtWrBanN, OtWrTaken}, 0);
    mq.delete();
    ovf_m = 1'b0;
    @(negedge Clk);
    Rest = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  // One clock: drive inputs, check outputs at negedge against the model,
  // then advance the model by the same transfer rules.
  task automatic cyc(input bit able, input logic [AW-1:0] pc, input logic [AW-1:0] tgt,
                     input logic [2:0] ty, input logic [1:0] bn, input bit tk,
                     input bit ack, input bit stop);
    int       n;
    bit       e_able;
    bit       e_mrg;
    bit       e_rdy;
    btb_upd_t ne;
    InUpdAble   = able;
    InUpdPc     = pc;
    InUpdTarget = tgt;
    InUpdType   = ty;
    InUpdBanN   = bn;
    InUpdTaken  = tk;
    InWrAck     = ack;
    BUstop      = stop;
    @(negedge Clk);
    n      = mq.size();
    e_able = (n != 0) && !stop;
    e_mrg  = 1'b0;
`ifdef BTB_UPD_MERGE_EN
    if (able && n != 0 && mq[n-1].Pc == pc && !(n == 1 && e_able && ack)) e_mrg = 1'b1;
`endif
    e_rdy = (n != DEPTH) || e_mrg;
    chk("able", OtWrAble, e_able);
    chk("cnt",  OtQueCnt, n);
    chk("rdy",  OtUpdReady, e_rdy);
    chk("ovf",  OtOverflow, ovf_m);
    if (n != 0) begin
      chk("pc",    OtWrPc, mq[0].Pc);
      chk("tgt",   OtWrTarget, mq[0].Target);
      chk("type",  OtWrType, mq[0].Type);
      chk("ban",   OtWrBanN, mq[0].BanN);
      chk("taken", OtWrTaken, mq[0].Taken);
    end
    ne.Pc = pc; ne.Target = tgt; ne.Type = ty; ne.BanN = bn; ne.Taken = tk;
    if (e_mrg) mq[n-1] = ne;
    else if (able && e_rdy) mq.push_back(ne);
    else if (able) ovf_m = 1'b1;
    if (e_able && ack) void'(mq.pop_front());
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input bit ack, input bit stop);
    cyc(1'b0, '0, '0, 3'd0, 2'd0, 1'b0, ack, stop);
  endtask

  initial begin
    Rest = 1'b1; BUstop = 1'b0; InUpdAble = 1'b0; InUpdPc = '0; InUpdTarget = '0;
    InUpdType = '0; InUpdBanN = '0; InUpdTaken = 1'b0; InWrAck = 1'b0;
    #2;
    do_reset();

    // Single update: write request exactly one cycle later, then empty.
    cyc(1'b1, 32'h1C000040, 32'h1C000100, 3'd1, 2'd2, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);

    // Fill with no acks, fifth update dropped, drain in order.
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 32'h1C001000 + 32'(i * 16), 32'h1C002000 + 32'(i), 3'(i), 2'(i), i[0], 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    chk("fill_ovf", OtOverflow, 1);
    for (int i = 0; i < 5; i++) idle(1'b1, 1'b0);
    chk("drain_ovf_sticky", OtOverflow, 1);
    do_reset();

    // BUstop holds two entries despite acks, then they drain.
    cyc(1'b1, 32'h1C000010, 32'h1C000A00, 3'd2, 2'd1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h1C000020, 32'h1C000B00, 3'd3, 2'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b0);
    do_reset();

    // Full with simultaneous ack and new update: update dropped.
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 32'h1C003000 + 32'(i * 4), 32'h1C004000, 3'd1, 2'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h1C00F000, 32'h1C00F100, 3'd5, 2'd1, 1'b0, 1'b1, 1'b0);
    chk("full_ack_cnt", OtQueCnt, 3);
    chk("full_ack_ovf", OtOverflow, 1);
    idle(1'b0, 1'b0);
    do_reset();

    // Back-to-back updates to the same PC.
    cyc(1'b1, 32'h1C000080, 32'h1C000200, 3'd1, 2'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h1C000080, 32'h1C000300, 3'd1, 2'd0, 1'b0, 1'b0, 1'b0);
`ifdef BTB_UPD_MERGE_EN
    chk("same_pc_cnt", OtQueCnt, 1);
    chk("same_pc_tgt", OtWrTarget, 32'h1C000300);
`else
    chk("same_pc_cnt", OtQueCnt, 2);
    chk("same_pc_tgt", OtWrTarget, 32'h1C000200);
`endif
    idle(1'b0, 1'b0);
    do_reset();

    // Random traffic with a small PC pool so same-PC runs occur.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      else cyc($urandom_range(0, 99) < 60,
               32'h1C000000 + 32'($urandom_range(0, 3) * 4),
               $urandom, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)),
               $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 15);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
